id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register of the pipelined MIPS datapath, directly downstream of the sign extender.
- Captures the 32-bit sign-extended immediate, register-file read data, register addresses and decoded control signals at the end of ID.
- Precomputes the registered branch target for EX.
- Supports hold (stall), bubble insertion (flush) and an optional internal load-use hazard detector.

---
 rtl/id_ex_pipe_reg.sv | 134 +++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the pipelined MIPS datapath.
// Captures operands, register addresses and decoded control at the end of ID,
// and precomputes the branch target (PC+4 + imm<<2) for EX.
// Supports stall (hold), flush (bubble) and an optional load-use hazard
// detector enabled by defining ID_EX_HAZARD_DETECT_EN.
module id_ex_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ALUOP_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic [DATA_W-1:0]  pc_plus4_i,
  input  logic [DATA_W-1:0]  rs_data_i,
  input  logic [DATA_W-1:0]  rt_data_i,
  input  logic [DATA_W-1:0]  sign_ext_i,
  input  logic [ADDR_W-1:0]  rs_addr_i,
  input  logic [ADDR_W-1:0]  rt_addr_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  input  logic [5:0]         funct_i,
  input  logic               reg_write_i,
  input  logic               mem_to_reg_i,
  input  logic               mem_read_i,
  input  logic               mem_write_i,
  input  logic               branch_i,
  input  logic               alu_src_i,
  input  logic               reg_dst_i,
  input  logic [ALUOP_W-1:0] alu_op_i,
  output logic               valid_o,
  output logic [DATA_W-1:0]  pc_plus4_o,
  output logic [DATA_W-1:0]  rs_data_o,
  output logic [DATA_W-1:0]  rt_data_o,
  output logic [DATA_W-1:0]  sign_ext_o,
  output logic [DATA_W-1:0]  branch_target_o,
  output logic [ADDR_W-1:0]  rs_addr_o,
  output logic [ADDR_W-1:0]  rt_addr_o,
  output logic [ADDR_W-1:0]  rd_addr_o,
  output logic [5:0]         funct_o,
  output logic               reg_write_o,
  output logic               mem_to_reg_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               branch_o,
  output logic               alu_src_o,
  output logic               reg_dst_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               stall_o
);

  logic              bubble;
  logic [DATA_W-1:0] branch_target;

`ifdef ID_EX_HAZARD_DETECT_EN
  logic hazard;

  // Load-use detection: EX holds a valid load whose destination feeds ID.
  always_comb begin
    hazard = valid_o & mem_read_o & (rt_addr_o != '0) & valid_i &
             ((rt_addr_o == rs_addr_i) | (rt_addr_o == rt_addr_i));
  end

  // Stall request goes upstream; an external hold outranks the internal bubble.
  always_comb begin
    stall_o = hazard;
    bubble  = flush_i | (hazard & ~stall_i);
  end
`else
  // Hazard detection compiled out: only an explicit flush makes a bubble.
  always_comb begin
    stall_o = 1'b0;
    bubble  = flush_i;
  end
`endif

  // Branch target wraps modulo 2^DATA_W.
  always_comb begin
    branch_target = pc_plus4_i + (sign_ext_i << 2);
  end

  // Data/address fields: load on normal load and on bubbles, hold on stall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_plus4_o      <= '0;
      rs_data_o       <= '0;
      rt_data_o       <= '0;
      sign_ext_o      <= '0;
      branch_target_o <= '0;
      rs_addr_o       <= '0;
      rt_addr_o       <= '0;
      rd_addr_o       <= '0;
      funct_o         <= '0;
    end else if (bubble || !stall_i) begin
      pc_plus4_o      <= pc_plus4_i;
      rs_data_o       <= rs_data_i;
      rt_data_o       <= rt_data_i;
      sign_ext_o      <= sign_ext_i;
      branch_target_o <= branch_target;
      rs_addr_o       <= rs_addr_i;
      rt_addr_o       <= rt_addr_i;
      rd_addr_o       <= rd_addr_i;
      funct_o         <= funct_i;
    end
  end

  // Valid and control: cleared by bubbles, held on stall. Controls are also
  // gated by valid_i so an invalid slot can never carry a write enable.
  always_ff @(posedge clk_i) begin
    if (rst_i || bubble) begin
      valid_o      <= 1'b0;
      reg_write_o  <= 1'b0;
      mem_to_reg_o <= 1'b0;
      mem_read_o   <= 1'b0;
      mem_write_o  <= 1'b0;
      branch_o     <= 1'b0;
      alu_src_o    <= 1'b0;
      reg_dst_o    <= 1'b0;
      alu_op_o     <= '0;
    end else if (!stall_i) begin
      valid_o      <= valid_i;
      reg_write_o  <= reg_write_i  & valid_i;
      mem_to_reg_o <= mem_to_reg_i & valid_i;
      mem_read_o   <= mem_read_i   & valid_i;
      mem_write_o  <= mem_write_i  & valid_i;
      branch_o     <= branch_i     & valid_i;
      alu_src_o    <= alu_src_i    & valid_i;
      reg_dst_o    <= reg_dst_i    & valid_i;
      alu_op_o     <= valid_i ? alu_op_i : '0;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: table-driven vectors plus
// hand-written load-use hazard sequences, checked through a scoreboard queue.
module tb_id_ex_pipe_reg;

`ifdef ID_EX_HAZARD_DETECT_EN
  localparam logic HZ_EN = 1'b1;
`else
  localparam logic HZ_EN = 1'b0;
`endif

  // ctrl bit order: reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst
  typedef struct packed {
    logic        rst, stall, flush, valid;
    logic [31:0] pc, rs_d, rt_d, se;
    logic [4:0]  rs_a, rt_a, rd_a;
    logic [5:0]  funct;
    logic [6:0]  ctrl;
    logic [2:0]  alu;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs_d, rt_d, se, bt;
    logic [4:0]  rs_a, rt_a, rd_a;
    logic [5:0]  funct;
    logic [6:0]  ctrl;
    logic [2:0]  alu;
  } out_t;

  typedef struct {
    in_t         in;
    logic [31:0] exp_bt;
    logic        exp_valid;
    logic [6:0]  exp_ctrl;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i, stall_i, flush_i, valid_i;
  logic [31:0] pc_plus4_i, rs_data_i, rt_data_i, sign_ext_i;
  logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
  logic [5:0]  funct_i;
  logic        reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, branch_i, alu_src_i, reg_dst_i;
  logic [2:0]  alu_op_i;
  logic        valid_o;
  logic [31:0] pc_plus4_o, rs_data_o, rt_data_o, sign_ext_o, branch_target_o;
  logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
  logic [5:0]  funct_o;
  logic        reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, branch_o, alu_src_o, reg_dst_o;
  logic [2:0]  alu_op_o;
  logic        stall_o;

  int   checks = 0;
  int   errors = 0;
  out_t m;
  logic m_known = 1'b0;
  out_t sb[$];
  vec_t tbl[14];

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.DATA_W(32), .ADDR_W(5), .ALUOP_W(3)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .pc_plus4_i(pc_plus4_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .sign_ext_i(sign_ext_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i), .funct_i(funct_i),
    .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .branch_i(branch_i), .alu_src_i(alu_src_i), .reg_dst_i(reg_dst_i),
    .alu_op_i(alu_op_i),
    .valid_o(valid_o), .pc_plus4_o(pc_plus4_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o),
    .sign_ext_o(sign_ext_o), .branch_target_o(branch_target_o),
    .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o), .funct_o(funct_o),
    .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .branch_o(branch_o), .alu_src_o(alu_src_o), .reg_dst_o(reg_dst_o),
    .alu_op_o(alu_op_o), .stall_o(stall_o)
  );

  function automatic in_t rand_in();
    in_t r;
    r.rst   = 1'b0;
    r.stall = 1'b0;
    r.flush = 1'b0;
    r.valid = 1'b1;
    r.pc    = $urandom;
    r.rs_d  = $urandom;
    r.rt_d  = $urandom;
    r.se    = $urandom;
    r.rs_a  = 5'($urandom);
    r.rt_a  = 5'($urandom);
    r.rd_a  = 5'($urandom);
    r.funct = 6'($urandom);
    r.ctrl  = 7'($urandom) & 7'h6F;  // no loads unless a test asks for one
    r.alu   = 3'($urandom);
    return r;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.valid = valid_o;
    o.pc    = pc_plus4_o;
    o.rs_d  = rs_data_o;
    o.rt_d  = rt_data_o;
    o.se    = sign_ext_o;
    o.bt    = branch_target_o;
    o.rs_a  = rs_addr_o;
    o.rt_a  = rt_addr_o;
    o.rd_a  = rd_addr_o;
    o.funct = funct_o;
    o.ctrl  = {reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, branch_o, alu_src_o, reg_dst_o};
    o.alu   = alu_op_o;
    return o;
  endfunction

  // Reference: load-use hazard seen from the current EX contents and ID inputs.
  function automatic logic hazard_model(out_t cur, in_t v);
    return HZ_EN & cur.valid & cur.ctrl[4] & (cur.rt_a != 5'd0) & v.valid &
           ((cur.rt_a == v.rs_a) | (cur.rt_a == v.rt_a));
  endfunction

  // Reference: next register contents.
  function automatic out_t model_next(out_t cur, in_t v, logic hz);
    out_t n;
    logic bub;
    n   = cur;
    bub = v.flush | (hz & ~v.stall);
    if (v.rst) begin
      n = '0;
    end else begin
      if (bub || !v.stall) begin
        n.pc    = v.pc;
        n.rs_d  = v.rs_d;
        n.rt_d  = v.rt_d;
        n.se    = v.se;
        n.bt    = v.pc + {v.se[29:0], 2'b00};
        n.rs_a  = v.rs_a;
        n.rt_a  = v.rt_a;
        n.rd_a  = v.rd_a;
        n.funct = v.funct;
      end
      if (bub) begin
        n.valid = 1'b0;
        n.ctrl  = '0;
        n.alu   = '0;
      end else if (!v.stall) begin
        n.valid = v.valid;
        n.ctrl  = v.valid ? v.ctrl : 7'd0;
        n.alu   = v.valid ? v.alu : 3'd0;
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input in_t v);
    rst_i      = v.rst;
    stall_i    = v.stall;
    flush_i    = v.flush;
    valid_i    = v.valid;
    pc_plus4_i = v.pc;
    rs_data_i  = v.rs_d;
    rt_data_i  = v.rt_d;
    sign_ext_i = v.se;
    rs_addr_i  = v.rs_a;
    rt_addr_i  = v.rt_a;
    rd_addr_i  = v.rd_a;
    funct_i    = v.funct;
    {reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, branch_i, alu_src_i, reg_dst_i} = v.ctrl;
    alu_op_i   = v.alu;
  endtask

  // Drive one cycle, check stall_o before the edge, scoreboard the result after it.
  task automatic step(input in_t v, input string tag);
    logic hz;
    out_t exp;
    drive(v);
    #1;
    hz = hazard_model(m, v);
    if (m_known) chk({tag, "_stall_o"}, 256'(stall_o), 256'(hz));
    m = model_next(m, v, hz);
    if (v.rst) m_known = 1'b1;
    sb.push_back(m);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 256'(0), 256'(1));
    end else begin
      exp = sb.pop_front();
      chk({tag, "_regs"}, 256'(dut_out()), 256'(exp));
    end
  endtask

  initial begin
    in_t v;
    for (int i = 0; i < 14; i++) begin
      tbl[i].in        = rand_in();
      tbl[i].exp_bt    = 32'h0;
      tbl[i].exp_valid = 1'b0;
      tbl[i].exp_ctrl  = 7'h00;
    end
    // 0-1: reset with random inputs
    tbl[0].in.rst = 1'b1; tbl[0].in.ctrl = 7'($urandom);
    tbl[1].in.rst = 1'b1; tbl[1].in.ctrl = 7'($urandom); tbl[1].in.flush = 1'b1;
    // 2: basic load, negative immediate
    tbl[2].in.pc = 32'h10; tbl[2].in.se = 32'hFFFF_FFFF; tbl[2].in.ctrl = 7'h40;
    tbl[2].exp_bt = 32'h0000_000C; tbl[2].exp_valid = 1'b1; tbl[2].exp_ctrl = 7'h40;
    // 3: branch target wrap
    tbl[3].in.pc = 32'hFFFF_FFFC; tbl[3].in.se = 32'h1; tbl[3].in.ctrl = 7'h04;
    tbl[3].exp_bt = 32'h0; tbl[3].exp_valid = 1'b1; tbl[3].exp_ctrl = 7'h04;
    // 4: flush beats stall, store must not survive
    tbl[4].in.flush = 1'b1; tbl[4].in.stall = 1'b1; tbl[4].in.pc = 32'h40; tbl[4].in.se = 32'h3;
    tbl[4].in.ctrl = 7'h08; tbl[4].in.alu = 3'd5;
    tbl[4].exp_bt = 32'h4C;
    // 5: load, then 6-8 stall with changing inputs, 9 release
    tbl[5].in.pc = 32'h100; tbl[5].in.se = 32'h10; tbl[5].in.ctrl = 7'h4B;
    tbl[5].exp_bt = 32'h140; tbl[5].exp_valid = 1'b1; tbl[5].exp_ctrl = 7'h4B;
    for (int i = 6; i < 9; i++) begin
      tbl[i].in.stall = 1'b1; tbl[i].in.valid = 1'($urandom);
      tbl[i].exp_bt = 32'h140; tbl[i].exp_valid = 1'b1; tbl[i].exp_ctrl = 7'h4B;
    end
    tbl[9].in.pc = 32'h200; tbl[9].in.se = 32'h2; tbl[9].in.ctrl = 7'h22;
    tbl[9].exp_bt = 32'h208; tbl[9].exp_valid = 1'b1; tbl[9].exp_ctrl = 7'h22;
    // 10: reset during stall
    tbl[10].in.rst = 1'b1; tbl[10].in.stall = 1'b1;
    // 11: large positive immediate overflows the shift
    tbl[11].in.pc = 32'h0; tbl[11].in.se = 32'h7FFF_FFFF; tbl[11].in.ctrl = 7'h6F;
    tbl[11].exp_bt = 32'hFFFF_FFFC; tbl[11].exp_valid = 1'b1; tbl[11].exp_ctrl = 7'h6F;
    // 12: reset during flush
    tbl[12].in.rst = 1'b1; tbl[12].in.flush = 1'b1;
    // 13: invalid instruction carries no control
    tbl[13].in.valid = 1'b0; tbl[13].in.pc = 32'h20; tbl[13].in.se = 32'h1; tbl[13].in.ctrl = 7'h4B;
    tbl[13].exp_bt = 32'h24;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].in, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_bt", i), 256'(branch_target_o), 256'(tbl[i].exp_bt));
      chk($sformatf("vec%0d_valid", i), 256'(valid_o), 256'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_ctrl", i), 256'({reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o,
                                             branch_o, alu_src_o, reg_dst_o}), 256'(tbl[i].exp_ctrl));
    end
    chk("reset_stall_o", 256'(stall_o), 256'(0));

    // Load-use: lw writing r5, followed by a consumer of r5
    v = rand_in(); v.ctrl = 7'h70; v.rt_a = 5'd5; v.alu = 3'd0;
    step(v, "lw5");
    v = rand_in(); v.ctrl = 7'h40; v.rs_a = 5'd5; v.rt_a = 5'd7;
    drive(v);
    #1;
    chk("lw5_use_stall_o", 256'(stall_o), 256'(HZ_EN));
    step(v, "lw5_use");
    chk("lw5_use_valid", 256'(valid_o), 256'(!HZ_EN));
    chk("lw5_use_regwrite", 256'(reg_write_o), 256'(!HZ_EN));
    step(v, "lw5_reissue");
    chk("lw5_reissue_valid", 256'(valid_o), 256'(1));
    chk("lw5_reissue_stall_o", 256'(stall_o), 256'(0));

    // Load to r0 never stalls
    v = rand_in(); v.ctrl = 7'h70; v.rt_a = 5'd0;
    step(v, "lw0");
    v = rand_in(); v.ctrl = 7'h40; v.rs_a = 5'd0; v.rt_a = 5'd0;
    drive(v);
    #1;
    chk("lw0_stall_o", 256'(stall_o), 256'(0));
    step(v, "lw0_use");
    chk("lw0_use_valid", 256'(valid_o), 256'(1));

    // Hazard on rt match while an external hold is active: hold wins, then bubble
    v = rand_in(); v.ctrl = 7'h70; v.rt_a = 5'd9;
    step(v, "lw9");
    v = rand_in(); v.ctrl = 7'h41; v.rs_a = 5'd3; v.rt_a = 5'd9; v.stall = 1'b1;
    drive(v);
    #1;
    chk("lw9_hold_stall_o", 256'(stall_o), 256'(HZ_EN));
    step(v, "lw9_hold");
    chk("lw9_hold_memread", 256'(mem_read_o), 256'(1));
    v.stall = 1'b0;
    step(v, "lw9_release");
    chk("lw9_release_valid", 256'(valid_o), 256'(!HZ_EN));

    // Matching address but ID slot invalid: no stall
    v = rand_in(); v.ctrl = 7'h70; v.rt_a = 5'd12;
    step(v, "lw12");
    v = rand_in(); v.valid = 1'b0; v.rs_a = 5'd12;
    drive(v);
    #1;
    chk("lw12_invalid_stall_o", 256'(stall_o), 256'(0));
    step(v, "lw12_invalid");

    for (int i = 0; i < 20; i++) begin
      v = rand_in();
      v.ctrl  = 7'($urandom);
      v.rs_a  = 5'($urandom_range(0, 3));
      v.rt_a  = 5'($urandom_range(0, 3));
      v.stall = ($urandom_range(0, 3) == 0);
      v.flush = ($urandom_range(0, 5) == 0);
      v.valid = ($urandom_range(0, 4) != 0);
      step(v, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
